// File: rtl/ariane_pkg.sv
// ---------------------------------------------------------------------------
// ariane_pkg: CVA6 dcache load-port request/response types and widths
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ariane_pkg;

  localparam int unsigned XLEN               = 64;
  localparam int unsigned PLEN               = 56;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [(XLEN/8)-1:0]           data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic            data_gnt;
    logic            data_rvalid;
    logic [XLEN-1:0] data_rdata;
  } dcache_req_o_t;

endpackage

`default_nettype wire

// File: rtl/ld_resp_pkg.sv
// ---------------------------------------------------------------------------
// ld_resp_pkg: FSM encoding and helpers for the load-port responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ld_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    MREQ  = 2'd2,
    MWAIT = 2'd3
  } ld_resp_state_e;

  function automatic bit entries_ok(int unsigned n);
    return (n >= 2) && (n <= 32) && ((n & (n - 1)) == 0);
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ld_resp_buffer.sv
// ---------------------------------------------------------------------------
// ld_resp_buffer: fully-associative word buffer, round-robin fill, flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ld_resp_buffer
  import ld_resp_pkg::*;
#(
  parameter int unsigned Entries   = 8,
  parameter int unsigned KeyWidth  = 53,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [KeyWidth-1:0]  lookup_key_i,
  output logic                 lookup_hit_o,
  output logic [DataWidth-1:0] lookup_data_o,
  input  logic                 fill_i,
  input  logic [KeyWidth-1:0]  fill_key_i,
  input  logic [DataWidth-1:0] fill_data_i
);

  localparam int unsigned PtrWidth = $clog2(Entries);

  logic [Entries-1:0]   valid_q, valid_d;
  logic [KeyWidth-1:0]  key_q  [Entries];
  logic [KeyWidth-1:0]  key_d  [Entries];
  logic [DataWidth-1:0] data_q [Entries];
  logic [DataWidth-1:0] data_d [Entries];
  logic [PtrWidth-1:0]  ptr_q, ptr_d;

  // Fills only happen on a miss, so at most one entry can match.
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    for (int i = 0; i < int'(Entries); i++) begin
      if (valid_q[i] && (key_q[i] == lookup_key_i)) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = data_q[i];
      end
    end
  end

  // A flush wins over a coincident fill; the pointer survives a flush.
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (fill_i) begin
      valid_d[ptr_q] = 1'b1;
      key_d[ptr_q]   = fill_key_i;
      data_d[ptr_q]  = fill_data_i;
      ptr_d          = ptr_q + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    key_q  <= key_d;
    data_q <= data_d;
  end

endmodule

`default_nettype wire

// File: rtl/ld_port_responder.sv
// ---------------------------------------------------------------------------
// ld_port_responder: dcache load-port responder with word buffer and memory port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ld_port_responder
  import ariane_pkg::*;
  import ld_resp_pkg::*;
#(
  parameter int unsigned Entries = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  dcache_req_i_t                                req_port_i,
  output dcache_req_o_t                                req_port_o,
  input  logic                                         flush_i,
  output logic                                         mem_req_o,
  output logic [DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:0] mem_addr_o,
  input  logic                                         mem_gnt_i,
  input  logic                                         mem_rvalid_i,
  input  logic [63:0]                                  mem_rdata_i,
  output logic [31:0]                                  hit_cnt_o,
  output logic [31:0]                                  miss_cnt_o
);

  localparam int unsigned IdxW  = DCACHE_INDEX_WIDTH;
  localparam int unsigned TagW  = DCACHE_TAG_WIDTH;
  localparam int unsigned AddrW = TagW + IdxW;
  localparam int unsigned KeyW  = AddrW - 3;

  if (!entries_ok(Entries)) begin : g_entries_check
    $error("ld_port_responder: Entries must be a power of two in 2..32");
  end

  ld_resp_state_e   state_q, state_d;
  logic [IdxW-1:0]  index_q, index_d;
  logic             we_q, we_d;
  logic             killed_q, killed_d;
  logic             rvalid_q, rvalid_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic             gnt;
  logic             mem_req;
  logic             fill;
  logic             hit;
  logic [63:0]      hit_data;
  logic [KeyW-1:0]  lookup_key;

  assign lookup_key = {req_port_i.address_tag, index_q[IdxW-1:3]};

  ld_resp_buffer #(
    .Entries   (Entries),
    .KeyWidth  (KeyW),
    .DataWidth (64)
  ) u_buffer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .lookup_key_i  (lookup_key),
    .lookup_hit_o  (hit),
    .lookup_data_o (hit_data),
    .fill_i        (fill),
    .fill_key_i    (mem_addr_q[AddrW-1:3]),
    .fill_data_i   (mem_rdata_i)
  );

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    we_d       = we_q;
    killed_d   = killed_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    gnt        = 1'b0;
    mem_req    = 1'b0;
    fill       = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt = req_port_i.data_req;
        if (req_port_i.data_req) begin
          index_d = req_port_i.address_index;
          we_d    = req_port_i.data_we;
          state_d = TAG;
        end
      end
      TAG: begin
        if (req_port_i.kill_req) begin
          state_d = IDLE;
        end else if (req_port_i.tag_valid) begin
          if (we_q) begin
            state_d = IDLE;
          end else if (hit) begin
            // Accepting the next request here gives one hit per cycle.
            rvalid_d  = 1'b1;
            rdata_d   = hit_data;
            hit_cnt_d = sat_inc(hit_cnt_q);
            gnt       = req_port_i.data_req;
            if (req_port_i.data_req) begin
              index_d = req_port_i.address_index;
              we_d    = req_port_i.data_we;
              state_d = TAG;
            end else begin
              state_d = IDLE;
            end
          end else begin
            mem_addr_d = {req_port_i.address_tag, index_q[IdxW-1:3], 3'b000};
            miss_cnt_d = sat_inc(miss_cnt_q);
            killed_d   = 1'b0;
            state_d    = MREQ;
          end
        end
      end
      MREQ: begin
        mem_req = 1'b1;
        if (req_port_i.kill_req) begin
          killed_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = MWAIT;
        end
      end
      MWAIT: begin
        if (mem_rvalid_i) begin
          fill     = 1'b1;
          rvalid_d = !(killed_q || req_port_i.kill_req);
          rdata_d  = mem_rdata_i;
          state_d  = IDLE;
        end else if (req_port_i.kill_req) begin
          killed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      index_q    <= '0;
      we_q       <= 1'b0;
      killed_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      we_q       <= we_d;
      killed_q   <= killed_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Handshake outputs are forced low for the whole reset window, not just after the edge.
  assign req_port_o.data_gnt    = gnt & ~rst_i;
  assign req_port_o.data_rvalid = rvalid_q & ~rst_i;
  assign req_port_o.data_rdata  = rdata_q;
  assign mem_req_o              = mem_req & ~rst_i;
  assign mem_addr_o             = mem_addr_q;
  assign hit_cnt_o              = hit_cnt_q;
  assign miss_cnt_o             = miss_cnt_q;

  logic unused_sink;
  assign unused_sink = ^{req_port_i.data_wdata, req_port_i.data_be,
                         req_port_i.data_size, index_q[2:0]};

endmodule

`default_nettype wire

// File: tb/tb_ld_port_responder.sv
// ---------------------------------------------------------------------------
// tb_ld_port_responder: directed self-checking bench for ld_port_responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ld_port_responder;
  import ariane_pkg::*;

  localparam int unsigned AW = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
  localparam logic [63:0] D0 = 64'hDEADBEEF_CAFEF00D;

  logic          clk = 1'b0;
  logic          rst;
  dcache_req_i_t req;
  dcache_req_o_t rsp;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ld_port_responder #(.Entries(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_port_i   (req),
    .req_port_o   (rsp),
    .flush_i      (flush),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req        = '0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // Full miss sequence: req, tag, MREQ (granted), one MWAIT cycle, rvalid cycle.
  task automatic miss_fill(input logic [11:0] idx, input logic [43:0] tag,
                           input logic [63:0] data, input bit kill_wait, input bit flush_fill);
    req.data_req = 1'b1; req.address_index = idx; cyc();
    req.data_req = 1'b0; req.address_tag = tag; req.tag_valid = 1'b1; cyc();
    req.tag_valid = 1'b0; mem_gnt = 1'b1; cyc();
    mem_gnt = 1'b0; req.kill_req = kill_wait; cyc();
    req.kill_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = data; flush = flush_fill; cyc();
    mem_rvalid = 1'b0; flush = 1'b0;
  endtask

  task automatic hit_read(input logic [11:0] idx, input logic [43:0] tag);
    req.data_req = 1'b1; req.address_index = idx; cyc();
    req.data_req = 1'b0; req.address_tag = tag; req.tag_valid = 1'b1; cyc();
    req.tag_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    req.data_req = 1'b1;
    cyc(); cyc();
    n_checks++; if (rsp.data_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b expected 0", rsp.data_gnt); end
    n_checks++; if (rsp.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b expected 0", rsp.data_rvalid); end
    n_checks++; if (rsp.data_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rsp.data_rdata); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_checks++; if ({hit_cnt, miss_cnt} !== 64'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    rst = 1'b0;
    req.data_req = 1'b0;
    cyc();
  endtask

  task automatic test_cold_miss();
    logic [AW-1:0] exp_addr;
    exp_addr = {44'h1234, 12'h040};
    req.data_req = 1'b1; req.address_index = 12'h040; #1;
    n_checks++; if (rsp.data_gnt !== 1'b1) begin n_fail++; $display("FAIL cold_gnt_req: got %0b expected 1", rsp.data_gnt); end
    cyc();
    req.data_req = 1'b0; req.address_tag = 44'h1234; req.tag_valid = 1'b1; #1;
    n_checks++; if (rsp.data_gnt !== 1'b0) begin n_fail++; $display("FAIL cold_gnt_tag: got %0b expected 0", rsp.data_gnt); end
    cyc();
    req.tag_valid = 1'b0;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL cold_mem_req: got %0b expected 1", mem_req); end
    n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL cold_mem_addr: got %h expected %h", mem_addr, exp_addr); end
    n_checks++; if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d expected 1", miss_cnt); end
    mem_gnt = 1'b1; cyc();
    mem_gnt = 1'b0; #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_mem_req_drop: got %0b expected 0", mem_req); end
    mem_rvalid = 1'b1; mem_rdata = D0; cyc();
    mem_rvalid = 1'b0;
    n_checks++; if (rsp.data_rvalid !== 1'b1) begin n_fail++; $display("FAIL cold_rvalid: got %0b expected 1", rsp.data_rvalid); end
    n_checks++; if (rsp.data_rdata !== D0) begin n_fail++; $display("FAIL cold_rdata: got %h expected %h", rsp.data_rdata, D0); end
    cyc();
    n_checks++; if (rsp.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL cold_rvalid_pulse: got %0b expected 0", rsp.data_rvalid); end
    n_checks++; if (rsp.data_rdata !== D0) begin n_fail++; $display("FAIL cold_rdata_hold: got %h expected %h", rsp.data_rdata, D0); end
  endtask

  task automatic test_back_to_back();
    req.address_index = 12'h040;
    req.address_tag   = 44'h1234;
    for (int i = 0; i < 6; i++) begin
      req.data_req  = (i < 4);
      req.tag_valid = (i >= 1) && (i <= 4);
      #1;
      if (i < 4) begin
        n_checks++; if (rsp.data_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %0b expected 1", i, rsp.data_gnt); end
      end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_mem_req[%0d]: got %0b expected 0", i, mem_req); end
      if (i >= 2) begin
        n_checks++; if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== D0) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %0b/%h expected 1/%h", i, rsp.data_rvalid, rsp.data_rdata, D0); end
      end
      cyc();
    end
    req.tag_valid = 1'b0;
    n_checks++; if (rsp.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_end: got %0b expected 0", rsp.data_rvalid); end
    n_checks++; if (hit_cnt !== 32'd4) begin n_fail++; $display("FAIL b2b_hit_cnt: got %0d expected 4", hit_cnt); end
  endtask

  task automatic test_kill();
    logic [63:0] kdata;
    kdata = 64'h0123_4567_89AB_CDEF;
    req.data_req = 1'b1; req.address_index = 12'h040; cyc();
    req.data_req = 1'b0; req.address_tag = 44'h1234; req.kill_req = 1'b1; cyc();
    req.kill_req = 1'b0;
    n_checks++; if (rsp.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL kill_tag_rvalid: got %0b expected 0", rsp.data_rvalid); end
    req.data_req = 1'b1; #1;
    n_checks++; if (rsp.data_gnt !== 1'b1) begin n_fail++; $display("FAIL kill_back_idle: got gnt %0b expected 1", rsp.data_gnt); end
    cyc();
    req.data_req = 1'b0; req.tag_valid = 1'b1; cyc();
    req.tag_valid = 1'b0;
    n_checks++; if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== D0) begin n_fail++; $display("FAIL kill_then_hit: got %0b/%h expected 1/%h", rsp.data_rvalid, rsp.data_rdata, D0); end
    miss_fill(12'h080, 44'h55, kdata, 1'b1, 1'b0);
    n_checks++; if (rsp.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL kill_wait_rvalid: got %0b expected 0", rsp.data_rvalid); end
    n_checks++; if (miss_cnt !== 32'd2) begin n_fail++; $display("FAIL kill_wait_miss_cnt: got %0d expected 2", miss_cnt); end
    hit_read(12'h080, 44'h55);
    n_checks++; if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== kdata) begin n_fail++; $display("FAIL kill_wait_refill_hit: got %0b/%h expected 1/%h", rsp.data_rvalid, rsp.data_rdata, kdata); end
    n_checks++; if (hit_cnt !== 32'd6 || miss_cnt !== 32'd2) begin n_fail++; $display("FAIL kill_counters: got %0d/%0d expected 6/2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_evict();
    idle_inputs();
    rst = 1'b1; cyc();
    rst = 1'b0; cyc();
    for (int k = 0; k < 9; k++) begin
      miss_fill(12'(12'h100 + k * 8), 44'(44'hA00 + k), 64'h1111_0000_0000_0000 + 64'(k), 1'b0, 1'b0);
      n_checks++; if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== 64'h1111_0000_0000_0000 + 64'(k)) begin n_fail++; $display("FAIL evict_fill[%0d]: got %0b/%h", k, rsp.data_rvalid, rsp.data_rdata); end
    end
    n_checks++; if (miss_cnt !== 32'd9) begin n_fail++; $display("FAIL evict_miss_cnt9: got %0d expected 9", miss_cnt); end
    hit_read(12'h108, 44'hA01);
    n_checks++; if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== 64'h1111_0000_0000_0001) begin n_fail++; $display("FAIL evict_second_hit: got %0b/%h expected 1/1111000000000001", rsp.data_rvalid, rsp.data_rdata); end
    miss_fill(12'h100, 44'hA00, 64'h2222_0000_0000_0000, 1'b0, 1'b0);
    n_checks++; if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== 64'h2222_0000_0000_0000) begin n_fail++; $display("FAIL evict_first_missed: got %0b/%h expected 1/2222000000000000", rsp.data_rvalid, rsp.data_rdata); end
    n_checks++; if (miss_cnt !== 32'd10 || hit_cnt !== 32'd1) begin n_fail++; $display("FAIL evict_counters: got miss %0d hit %0d expected 10/1", miss_cnt, hit_cnt); end
  endtask

  task automatic test_flush_reset();
    logic [AW-1:0] exp_addr;
    miss_fill(12'h200, 44'h77, 64'hF1F1_F1F1_0000_0001, 1'b0, 1'b1);
    n_checks++; if (rsp.data_rvalid !== 1'b1 || rsp.data_rdata !== 64'hF1F1_F1F1_0000_0001) begin n_fail++; $display("FAIL flush_fill_data: got %0b/%h", rsp.data_rvalid, rsp.data_rdata); end
    miss_fill(12'h200, 44'h77, 64'hF2F2_F2F2_0000_0002, 1'b0, 1'b0);
    n_checks++; if (rsp.data_rdata !== 64'hF2F2_F2F2_0000_0002) begin n_fail++; $display("FAIL flush_fill_not_written: got %h expected f2f2f2f200000002", rsp.data_rdata); end
    miss_fill(12'h140, 44'hA08, 64'hF3F3_F3F3_0000_0003, 1'b0, 1'b0);
    n_checks++; if (rsp.data_rdata !== 64'hF3F3_F3F3_0000_0003) begin n_fail++; $display("FAIL flush_cleared_all: got %h expected f3f3f3f300000003", rsp.data_rdata); end
    n_checks++; if (miss_cnt !== 32'd13) begin n_fail++; $display("FAIL flush_miss_cnt: got %0d expected 13", miss_cnt); end
    exp_addr = {44'h99, 12'h300};
    req.data_req = 1'b1; req.address_index = 12'h305; cyc();
    req.data_req = 1'b0; req.address_tag = 44'h99; req.tag_valid = 1'b1; cyc();
    req.tag_valid = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin n_fail++; $display("FAIL rst_mreq_addr: got %0b/%h expected 1/%h", mem_req, mem_addr, exp_addr); end
    rst = 1'b1; req.data_req = 1'b1; cyc();
    n_checks++; if (rsp.data_gnt !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_handshake: got gnt %0b mem_req %0b expected 0/0", rsp.data_gnt, mem_req); end
    n_checks++; if (rsp.data_rvalid !== 1'b0 || rsp.data_rdata !== 64'd0) begin n_fail++; $display("FAIL rst_mid_resp: got %0b/%h expected 0/0", rsp.data_rvalid, rsp.data_rdata); end
    n_checks++; if (mem_addr !== '0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_mid_regs: got %h/%0d/%0d expected 0/0/0", mem_addr, hit_cnt, miss_cnt); end
    rst = 1'b0; req.data_req = 1'b0; cyc();
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; cyc();
    mem_rvalid = 1'b0;
    n_checks++; if (rsp.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid: got %0b expected 0", rsp.data_rvalid); end
    cyc();
    n_checks++; if (rsp.data_rvalid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_after: got rvalid %0b mem_req %0b expected 0/0", rsp.data_rvalid, mem_req); end
    req.data_req = 1'b1; req.address_index = 12'h040; #1;
    n_checks++; if (rsp.data_gnt !== 1'b1) begin n_fail++; $display("FAIL post_reset_gnt: got %0b expected 1", rsp.data_gnt); end
    req.data_req = 1'b0; #1;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_kill();
    test_evict();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
